// File: rtl/board_io_if.sv
// Board-side bundle for board_io_ctrl: buttons, MAC results, display.
// slave = controller side, master = board/system side driving it.
interface board_io_if #(
  parameter int N_BTN  = 3,
  parameter int N_MACS = 4,
  parameter int ACC_W  = 16,
  parameter int LED_W  = 4
);
  localparam int NPAGES = 1 + N_MACS * (ACC_W / LED_W);
  localparam int PAGE_W = $clog2(NPAGES);

  logic [N_BTN-1:0]        btn_raw;
  logic [N_BTN-1:0]        btn_level;
  logic [N_BTN-1:0]        btn_press;
  logic [N_BTN-1:0]        btn_release;
  logic                    busy;
  logic [N_MACS-1:0]       valid_in;
  logic [N_MACS*ACC_W-1:0] acc_flat;
  logic                    clear_snap;
  logic                    mode_step;
  logic                    auto_en;
  logic [PAGE_W-1:0]       page;
  logic [N_MACS-1:0]       sticky;
  logic [LED_W-1:0]        led;

  modport slave (
    input  btn_raw, busy, valid_in, acc_flat,
    input  clear_snap, mode_step, auto_en,
    output btn_level, btn_press, btn_release,
    output page, sticky, led
  );

  modport master (
    output btn_raw, busy, valid_in, acc_flat,
    output clear_snap, mode_step, auto_en,
    input  btn_level, btn_press, btn_release,
    input  page, sticky, led
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board front end: button debounce, result snapshots, paged LED display.
// Ports: clk, rst_n (async low), io (board_io_if.slave bundle).
module board_io_ctrl #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int N_MACS          = 4,
  parameter int ACC_W           = 16,
  parameter int LED_W           = 4,
  parameter int AUTO_DWELL      = 62500000
) (
  input logic       clk,
  input logic       rst_n,
  board_io_if.slave io
);
  localparam int NIB    = ACC_W / LED_W;
  localparam int NPAGES = 1 + N_MACS * NIB;
  localparam int PAGE_W = $clog2(NPAGES);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W   = $clog2(AUTO_DWELL);

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0]   DW_MAX  = DW_W'(AUTO_DWELL - 1);
  localparam logic [PAGE_W-1:0] PG_MAX  = PAGE_W'(NPAGES - 1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] lvl_q, lvl_d;
  logic [N_BTN-1:0] prs_q, prs_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  logic [N_MACS*ACC_W-1:0] snap_q, snap_d;
  logic [N_MACS-1:0]       sticky_q, sticky_d;

  logic [PAGE_W-1:0] page_q, page_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              adv;

  logic [LED_W-1:0]        led_q, led_d;
  logic [N_MACS+LED_W-1:0] sticky_pad;

  always_comb begin
    s1_d  = io.btn_raw;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    prs_d = '0;
    rel_d = '0;
    for (int b = 0; b < N_BTN; b++) begin
      cnt_d[b] = '0;
      if (s2_q[b] != lvl_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          lvl_d[b] = s2_q[b];
          prs_d[b] = s2_q[b];
          rel_d[b] = ~s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // Capture beats clear, independently per channel.
  always_comb begin
    snap_d   = snap_q;
    sticky_d = sticky_q;
    for (int c = 0; c < N_MACS; c++) begin
      if (io.valid_in[c]) begin
        snap_d[c*ACC_W +: ACC_W] = io.acc_flat[c*ACC_W +: ACC_W];
        sticky_d[c]              = 1'b1;
      end else if (io.clear_snap) begin
        snap_d[c*ACC_W +: ACC_W] = '0;
        sticky_d[c]              = 1'b0;
      end
    end
  end

  // A manual step and an auto tick in one cycle merge into one advance.
  always_comb begin
    adv     = 1'b0;
    dwell_d = '0;
    if (io.mode_step) begin
      adv = 1'b1;
    end else if (io.auto_en) begin
      if (dwell_q == DW_MAX) begin
        adv = 1'b1;
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
    page_d = page_q;
    if (adv) begin
      page_d = (page_q == PG_MAX) ? '0 : page_q + PAGE_W'(1);
    end
  end

  assign sticky_pad = {{LED_W{1'b0}}, sticky_q};

  // Page 1.. walk channel-major, least-significant nibble first.
  always_comb begin
    led_d = '0;
    if (page_q == '0) begin
      led_d[LED_W-1] = io.busy;
      for (int i = 0; i < LED_W - 1; i++) begin
        led_d[i] = sticky_pad[i];
      end
    end else begin
      for (int c = 0; c < N_MACS; c++) begin
        for (int k = 0; k < NIB; k++) begin
          if (page_q == PAGE_W'(1 + c*NIB + k)) begin
            led_d = snap_q[c*ACC_W + k*LED_W +: LED_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      lvl_q    <= '0;
      prs_q    <= '0;
      rel_q    <= '0;
      for (int b = 0; b < N_BTN; b++) begin
        cnt_q[b] <= '0;
      end
      snap_q   <= '0;
      sticky_q <= '0;
      page_q   <= '0;
      dwell_q  <= '0;
      led_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      lvl_q    <= lvl_d;
      prs_q    <= prs_d;
      rel_q    <= rel_d;
      for (int b = 0; b < N_BTN; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      snap_q   <= snap_d;
      sticky_q <= sticky_d;
      page_q   <= page_d;
      dwell_q  <= dwell_d;
      led_q    <= led_d;
    end
  end

  assign io.btn_level   = lvl_q;
  assign io.btn_press   = prs_q;
  assign io.btn_release = rel_q;
  assign io.page        = page_q;
  assign io.sticky      = sticky_q;
  assign io.led         = led_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_board_io_ctrl;
  localparam int NB  = 3;
  localparam int DB  = 4;
  localparam int NM  = 4;
  localparam int AW  = 16;
  localparam int LW  = 4;
  localparam int AD  = 3;
  localparam int NIB = AW / LW;
  localparam int NP  = 1 + NM * NIB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  board_io_if #(.N_BTN(NB), .N_MACS(NM), .ACC_W(AW), .LED_W(LW)) io ();

  board_io_ctrl #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .N_MACS(NM),
    .ACC_W(AW), .LED_W(LW), .AUTO_DWELL(AD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NB-1:0]         s1;
    logic [NB-1:0]         s2;
    logic [NB-1:0]         level;
    logic [NB-1:0]         press;
    logic [NB-1:0]         rel;
    logic [NB-1:0][7:0]    run;
    logic [NM-1:0][AW-1:0] snap;
    logic [NM-1:0]         sticky;
    logic [7:0]            page;
    logic [7:0]            dwell;
    logic [LW-1:0]         led;
  } model_t;

  model_t m;

  function automatic logic [LW-1:0] led_of(model_t s, logic bsy);
    int idx, c, k;
    led_of = '0;
    if (s.page == 8'd0) begin
      led_of[LW-1] = bsy;
      for (int i = 0; i < LW - 1; i++) begin
        if (i < NM) led_of[i] = s.sticky[i];
      end
    end else begin
      idx = int'(s.page) - 1;
      c = idx / NIB;
      k = idx % NIB;
      led_of = LW'(s.snap[c] >> (k * LW));
    end
  endfunction

  // A button level flips once its synchronised value has disagreed
  // for DB consecutive clock edges.
  function automatic model_t step_model(
    model_t s, logic [NB-1:0] raw, logic bsy, logic [NM-1:0] vin,
    logic [NM*AW-1:0] acc, logic clr, logic stp, logic aen
  );
    model_t n;
    logic go;
    n = s;
    n.led = led_of(s, bsy);
    n.s1 = raw;
    n.s2 = s.s1;
    n.press = '0;
    n.rel = '0;
    for (int b = 0; b < NB; b++) begin
      if (s.s2[b] != s.level[b]) begin
        n.run[b] = s.run[b] + 8'd1;
        if (int'(n.run[b]) == DB) begin
          n.level[b] = s.s2[b];
          n.run[b] = 8'd0;
          if (s.s2[b]) n.press[b] = 1'b1;
          else n.rel[b] = 1'b1;
        end
      end else begin
        n.run[b] = 8'd0;
      end
    end
    for (int c = 0; c < NM; c++) begin
      if (vin[c]) begin
        n.snap[c] = acc[c*AW +: AW];
        n.sticky[c] = 1'b1;
      end else if (clr) begin
        n.snap[c] = '0;
        n.sticky[c] = 1'b0;
      end
    end
    go = 1'b0;
    n.dwell = 8'd0;
    if (stp) begin
      go = 1'b1;
    end else if (aen) begin
      n.dwell = s.dwell + 8'd1;
      if (int'(n.dwell) == AD) begin
        go = 1'b1;
        n.dwell = 8'd0;
      end
    end
    if (go) n.page = 8'((int'(s.page) + 1) % NP);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step_model(m, io.btn_raw, io.busy, io.valid_in,
                         io.acc_flat, io.clear_snap, io.mode_step,
                         io.auto_en);
  end

  always @(negedge clk) begin
    check("btn_level", 64'(io.btn_level), 64'(m.level));
    check("btn_press", 64'(io.btn_press), 64'(m.press));
    check("btn_release", 64'(io.btn_release), 64'(m.rel));
    check("page", 64'(io.page), 64'(m.page));
    check("sticky", 64'(io.sticky), 64'(m.sticky));
    check("led", 64'(io.led), 64'(m.led));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    io.mode_step = 1'b1;
    repeat (n) tick();
    io.mode_step = 1'b0;
  endtask

  int n;
  int np;

  initial begin
    io.btn_raw = '0;
    io.busy = 1'b0;
    io.valid_in = '0;
    io.acc_flat = '0;
    io.clear_snap = 1'b0;
    io.mode_step = 1'b0;
    io.auto_en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 64'(io.btn_level), 64'd0);
    check("rst_page", 64'(io.page), 64'd0);
    check("rst_led", 64'(io.led), 64'd0);
    check("rst_sticky", 64'(io.sticky), 64'd0);
    rst_n = 1'b1;
    tick();

    // clean press / release on button 0
    io.btn_raw[0] = 1'b1;
    n = 0;
    while (!io.btn_level[0] && n < 20) begin tick(); n++; end
    check("press_latency", 64'(n), 64'(2 + DB));
    check("press_pulse", 64'(io.btn_press), 64'b001);
    tick();
    check("press_width", 64'(io.btn_press[0]), 64'd0);
    repeat (3) tick();
    io.btn_raw[0] = 1'b0;
    n = 0;
    while (!io.btn_release[0] && n < 20) begin tick(); n++; end
    check("release_latency", 64'(n), 64'(2 + DB));
    check("release_level", 64'(io.btn_level[0]), 64'd0);
    tick();
    check("release_width", 64'(io.btn_release[0]), 64'd0);

    // bouncing button 1
    np = 0;
    for (int i = 0; i < 20; i++) begin
      io.btn_raw[1] = ((i / 2) % 2) == 0;
      tick();
      np += int'(io.btn_press[1]);
    end
    check("bounce_quiet", 64'(np), 64'd0);
    io.btn_raw[1] = 1'b1;
    n = 0;
    while (!io.btn_level[1] && n < 20) begin
      tick(); n++;
      np += int'(io.btn_press[1]);
    end
    check("bounce_latency", 64'(n), 64'(2 + DB));
    repeat (5) begin tick(); np += int'(io.btn_press[1]); end
    check("bounce_presses", 64'(np), 64'd1);

    // snapshot and nibble pages
    io.acc_flat[2*AW +: AW] = 16'hA5C3;
    io.valid_in = 4'b0100;
    tick();
    io.valid_in = '0;
    steps(9);
    check("page9", 64'(io.page), 64'd9);
    tick();
    check("led_p9", 64'(io.led), 64'h3);
    steps(1); tick();
    check("led_p10", 64'(io.led), 64'hC);
    steps(2); tick();
    check("page12", 64'(io.page), 64'd12);
    check("led_p12", 64'(io.led), 64'hA);
    steps(5);
    check("page_wrap0", 64'(io.page), 64'd0);
    io.busy = 1'b1;
    tick();
    check("led_status", 64'(io.led), 64'b1100);
    io.busy = 1'b0;

    // clear against capture
    io.acc_flat = {4{16'h1111}};
    io.valid_in = 4'b1111;
    tick();
    io.valid_in = '0;
    check("sticky_all", 64'(io.sticky), 64'hF);
    io.acc_flat[AW +: AW] = 16'h0042;
    io.clear_snap = 1'b1;
    io.valid_in = 4'b0010;
    tick();
    io.clear_snap = 1'b0;
    io.valid_in = '0;
    check("sticky_clr", 64'(io.sticky), 64'b0010);
    steps(5); tick();
    check("led_c1k0", 64'(io.led), 64'h2);
    steps(1); tick();
    check("led_c1k1", 64'(io.led), 64'h4);
    steps(3); tick();
    check("led_c2_cleared", 64'(io.led), 64'h0);

    // auto scroll and wrap
    steps(8);
    check("auto_start", 64'(io.page), 64'd0);
    io.auto_en = 1'b1;
    repeat (AD) tick();
    check("auto_p1", 64'(io.page), 64'd1);
    repeat (AD * 15) tick();
    check("auto_p16", 64'(io.page), 64'd16);
    repeat (AD) tick();
    check("auto_wrap", 64'(io.page), 64'd0);
    repeat (AD - 1) tick();
    io.mode_step = 1'b1;
    tick();
    io.mode_step = 1'b0;
    check("step_on_tick", 64'(io.page), 64'd1);
    repeat (AD - 1) tick();
    check("dwell_restart", 64'(io.page), 64'd1);
    tick();
    check("dwell_next", 64'(io.page), 64'd2);
    io.auto_en = 1'b0;

    // random traffic
    repeat (1500) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(5) == 0) io.btn_raw[b] = ~io.btn_raw[b];
      end
      io.busy = 1'($urandom_range(1));
      for (int c = 0; c < NM; c++) begin
        io.valid_in[c] = ($urandom_range(7) == 0);
      end
      io.acc_flat = {$urandom(), $urandom()};
      io.clear_snap = ($urandom_range(19) == 0);
      io.mode_step = ($urandom_range(9) == 0);
      if ($urandom_range(29) == 0) io.auto_en = ~io.auto_en;
      tick();
    end
    io.valid_in = '0;
    io.clear_snap = 1'b0;
    io.mode_step = 1'b0;
    io.auto_en = 1'b0;
    tick();

    // asynchronous reset in the middle of activity
    n = 0;
    while (m.page != 8'd5 && n < 40) begin
      io.mode_step = 1'b1;
      tick();
      n++;
    end
    io.mode_step = 1'b0;
    check("pre_rst_page", 64'(io.page), 64'd5);
    io.valid_in = '1;
    tick();
    io.valid_in = '0;
    check("pre_rst_sticky", 64'(io.sticky), 64'hF);
    io.btn_raw = ~m.level;
    repeat (3) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_level", 64'(io.btn_level), 64'd0);
    check("arst_press", 64'(io.btn_press), 64'd0);
    check("arst_release", 64'(io.btn_release), 64'd0);
    check("arst_page", 64'(io.page), 64'd0);
    check("arst_sticky", 64'(io.sticky), 64'd0);
    check("arst_led", 64'(io.led), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
